// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// load/store funct3 codes and the access legality rule.
package load_store_unit_pkg;

  localparam int LSU_WORD_ADDR_BITS = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // True when the code is defined for the direction and the address is
  // naturally aligned for its size.
  function automatic logic access_legal(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic legal;
    legal = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB:   legal = 1'b1;
        F3_SH:   legal = ~addr_lo[0];
        F3_SW:   legal = (addr_lo == 2'b00);
        default: legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: legal = 1'b1;
        F3_LH, F3_LHU: legal = ~addr_lo[0];
        F3_LW:         legal = (addr_lo == 2'b00);
        default:       legal = 1'b0;
      endcase
    end
    return legal;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane logic: extracts/extends load data from a memory word and
// replicates store data across lanes with the matching byte enables.
import load_store_unit_pkg::*;

module lsu_lane_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data,
  output logic [3:0]  store_be
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

  // NOTE: every output gets a default first so no path leaves one unassigned
  // and always_comb never infers a latch.
  always_comb begin
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   load_data = rdata;
      F3_LBU:  load_data = {24'd0, byte_sel};
      F3_LHU:  load_data = {16'd0, half_sel};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    store_data = '0;
    store_be   = 4'b0000;
    case (funct3)
      F3_SB: begin
        store_data = {4{wdata[7:0]}};
        store_be   = 4'b0001 << addr_lo;
      end
      F3_SH: begin
        store_data = {2{wdata[15:0]}};
        store_be   = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      F3_SW: begin
        store_data = wdata;
        store_be   = 4'b1111;
      end
      default: begin
        store_data = '0;
        store_be   = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: latches one request in IDLE, drives a word
// memory with wait-state support and returns an aligned, extended load result.
import load_store_unit_pkg::*;

module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int WORD_ADDR_BITS = LSU_WORD_ADDR_BITS
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [2:0]                funct3_i,
  input  logic [31:0]               byte_addr_i,
  input  logic [DATA_WIDTH-1:0]     wd_i,
  input  logic                      mwr_i,
  input  logic                      mrd_i,
  output logic [DATA_WIDTH-1:0]     rd_o,
  output logic                      mem_rdy_o,
  output logic                      err_o,
  output logic [WORD_ADDR_BITS-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [3:0]                mem_be_o,
  output logic                      mem_we_o,
  output logic                      mem_re_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  input  logic                      mem_busy_i
);

  lsu_state_e state_q, state_d;

  logic [WORD_ADDR_BITS+1:0] addr_q;
  logic [2:0]                funct3_q;
  logic [DATA_WIDTH-1:0]     wd_q;
  logic [DATA_WIDTH-1:0]     rd_q;
  logic                      err_q;

  logic                  req_any;
  logic                  req_legal;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_data;
  logic [3:0]            store_be;

  // Address bits above the 4 KiB window are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^byte_addr_i[31:WORD_ADDR_BITS+2];

  assign req_any   = mwr_i | mrd_i;
  assign req_legal = access_legal(mwr_i, funct3_i, byte_addr_i[1:0]);

  lsu_lane_align u_lane_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .rdata      (mem_rdata_i),
    .wdata      (wd_q),
    .load_data  (load_data),
    .store_data (store_data),
    .store_be   (store_be)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (!req_legal)  state_d = DONE;
          else if (mwr_i)  state_d = WR_WAIT;
          else             state_d = RD_WAIT;
        end
      end
      RD_WAIT: if (!mem_busy_i) state_d = DONE;
      WR_WAIT: if (!mem_busy_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and not
  // in the sensitivity list; all state updates use non-blocking assignment so
  // every register sees pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      wd_q     <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_any) begin
        addr_q   <= byte_addr_i[WORD_ADDR_BITS+1:0];
        funct3_q <= funct3_i;
        wd_q     <= wd_i;
        err_q    <= ~req_legal;
      end
      if (state_q == RD_WAIT && !mem_busy_i) begin
        rd_q <= load_data;
      end
    end
  end

  assign mem_re_o    = (state_q == RD_WAIT);
  assign mem_we_o    = (state_q == WR_WAIT);
  assign mem_addr_o  = addr_q[WORD_ADDR_BITS+1:2];
  assign mem_be_o    = mem_we_o ? store_be : 4'b0000;
  assign mem_wdata_o = mem_we_o ? store_data : '0;
  assign mem_rdy_o   = (state_q == DONE);
  assign err_o       = (state_q == DONE) && err_q;
  assign rd_o        = rd_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, data path width.
- WORD_ADDR_BITS, 10, memory word-address width (1024 words, 4 KiB).

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  reset, synchronous, active-low.
- funct3_i  in  3  access size/sign code, RV32I load/store encoding.
- byte_addr_i  in  32  byte address of the access.
- wd_i  in  32  store data, right-justified.
- mwr_i  in  1  store request.
- mrd_i  in  1  load request.
- rd_o  out  32  aligned, extended load result, registered; feeds the instruction register and MDR.
- mem_rdy_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle misaligned/illegal-access pulse.
- mem_addr_o  out  WORD_ADDR_BITS  word address to memory array.
- mem_wdata_o  out  32  lane-shifted store data.
- mem_be_o  out  4  byte-lane enables.
- mem_we_o  out  1  memory write strobe.
- mem_re_o  out  1  memory read strobe.
- mem_rdata_i  in  32  memory read word.
- mem_busy_i  in  1  memory wait-state; high stalls the current access.

Function
REQ-003 Clock is clk_i only; reset_i is synchronous and active-low; no other clock or reset exists.
REQ-004 FSM states: IDLE, RD_WAIT, WR_WAIT, DONE.
REQ-005 Requests are sampled only in IDLE; requests in any other state are ignored and not queued.
REQ-006 IDLE transitions:
- mwr_i=1 goes to WR_WAIT.
- mrd_i=1 with mwr_i=0 goes to RD_WAIT.
- Both high: the store wins.
REQ-007 At request sampling, address, funct3 and store data are latched; later input changes do not affect the access.
REQ-008 mem_addr_o = latched byte_addr[WORD_ADDR_BITS+1:2]; higher address bits are ignored (wrap modulo 4 KiB).
REQ-009 mem_re_o/mem_we_o are high throughout RD_WAIT/WR_WAIT respectively and low in every other state.
REQ-010 RD_WAIT/WR_WAIT are held while mem_busy_i=1; the first cycle with mem_busy_i=0 completes the access.
REQ-011 On load completion, mem_rdata_i is captured, aligned and extended into rd_o, and the FSM goes to DONE.
REQ-012 On store completion, the FSM goes to DONE.
REQ-013 In DONE, mem_rdy_o=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-014 Minimum latency with no wait-states is request edge plus 2 cycles to mem_rdy_o.
REQ-015 Load funct3 codes (lane chosen by addr[1:0] or addr[1]):
- 000 LB: sign-extend byte.
- 001 LH: sign-extend half.
- 010 LW: full word.
- 100 LBU: zero-extend byte.
- 101 LHU: zero-extend half.
REQ-016 Store funct3 codes:
- 000 SB: mem_be_o one-hot at addr[1:0], byte replicated across lanes.
- 001 SH: mem_be_o 0011 or 1100 by addr[1].
- 010 SW: mem_be_o 1111.
REQ-017 mem_be_o=0000 whenever mem_we_o=0.
REQ-018 Misaligned accesses (half with addr[0]=1; word with addr[1:0]≠00) and reserved codes (loads 011/110/111, stores other than 000/001/010):
- No memory strobe is issued.
- The FSM goes directly to DONE.
- err_o and mem_rdy_o pulse together.
- rd_o is unchanged.
REQ-019 rd_o holds its value until the next successful load completes; stores never change rd_o.

Reset
REQ-020 With reset_i=0 at a clock edge: state=IDLE, rd_o=0, mem_rdy_o=0, err_o=0, mem_re_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-021 Reset mid-access abandons the access; strobes drop on that same edge and no mem_rdy_o is issued for it.

Structure
REQ-022 A shared package holds: the FSM state enum, funct3 load/store constants, and WORD_ADDR_BITS default.
REQ-023 One combinational sub-module, lsu_lane_align, performs load extraction/extension and store lane shifting/enables.

Verification
REQ-024 LW, addr 0xFFC, mem word 0x04082983, no busy -> mem_addr_o=0x3FF, rd_o=0x04082983, mem_rdy_o two cycles after request.
REQ-025 LB, addr 0x003, word 0x80FF_0000 -> rd_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-026 SH, addr 0x006, wd 0x0000_BEEF -> mem_be_o=1100, mem_wdata_o=0xBEEF_BEEF, mem_we_o one cycle.
REQ-027 LW with mem_busy_i high for 3 cycles -> mem_re_o held 4 cycles, single mem_rdy_o pulse, rd_o updated once.
REQ-028 LH at addr 0x001 -> err_o and mem_rdy_o pulse next cycle, mem_re_o never asserted, rd_o unchanged.
REQ-029 reset_i low during RD_WAIT -> mem_re_o=0 next edge, no mem_rdy_o; subsequent LW at 0x1000 -> mem_addr_o=0x000.
